// File: rtl/udp_rx_demux.sv
// ---------------------------------------------------------------------------
// udp_rx_demux
// UDP receive stage. Parses and strips the 8-byte UDP header from the IP
// payload byte stream and steers the datagram payload to one of NUM_CH
// application channels selected by destination port. tlast is regenerated
// from the UDP length field, so trailing Ethernet padding is discarded.
// Short, malformed and unmatched datagrams are dropped and counted.
//
// Ports
//   clk, reset_n              clock, asynchronous active-low reset
//   udp_axis_*                input byte stream (header first), AXI-Stream
//   cfg_port_in / cfg_en_in   per-channel destination port and enable
//   udpdata_*                 payload stream; shared data/last, one-hot valid,
//                             per-channel ready
//   hdr_valid_out             pulse when a matching header completes
//   src_port_out, dest_port_out, udpdata_length_out, ch_out
//                             fields of the last matched header
//   err_short_out, err_len_out, drop_out
//                             single-cycle event pulses
//   frame_cnt_out, drop_cnt_out
//                             wrapping statistics counters
// ---------------------------------------------------------------------------
module udp_rx_demux #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [7:0]           udp_axis_tdata_in,
  input  logic                 udp_axis_tvalid_in,
  input  logic                 udp_axis_tlast_in,
  output logic                 udp_axis_tready_out,
  input  logic [16*NUM_CH-1:0] cfg_port_in,
  input  logic [NUM_CH-1:0]    cfg_en_in,
  output logic [7:0]           udpdata_tdata_out,
  output logic [NUM_CH-1:0]    udpdata_tvalid_out,
  output logic                 udpdata_tlast_out,
  input  logic [NUM_CH-1:0]    udpdata_tready_in,
  output logic                 hdr_valid_out,
  output logic [15:0]          src_port_out,
  output logic [15:0]          dest_port_out,
  output logic [15:0]          udpdata_length_out,
  output logic [CH_W-1:0]      ch_out,
  output logic                 err_short_out,
  output logic                 err_len_out,
  output logic                 drop_out,
  output logic [CNT_W-1:0]     frame_cnt_out,
  output logic [CNT_W-1:0]     drop_cnt_out
);

  typedef enum logic [1:0] {S_HDR = 2'd0, S_PAYLOAD = 2'd1, S_DROP = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [2:0]         hcnt_q, hcnt_d;
  logic [15:0]        hsrc_q, hsrc_d;      // header capture shadows
  logic [15:0]        hdst_q, hdst_d;
  logic [15:0]        hlen_q, hlen_d;
  logic [15:0]        rem_q, rem_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [15:0]        src_q, src_d;
  logic [15:0]        dst_q, dst_d;
  logic [15:0]        ulen_q, ulen_d;
  logic [7:0]         data_q, data_d;
  logic [NUM_CH-1:0]  vld_q, vld_d;
  logic               last_q, last_d;
  logic               hdr_vld_q, hdr_vld_d;
  logic               err_short_q, err_short_d;
  logic               err_len_q, err_len_d;
  logic               drop_q, drop_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

  logic               hit;
  logic [CH_W-1:0]    hit_ch;
  logic               acc;

  // Lowest-index enabled channel whose port matches wins: scanning downward
  // lets the last assignment be the lowest index.
  always_comb begin
    hit    = 1'b0;
    hit_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (cfg_en_in[i] && (cfg_port_in[16*i +: 16] == hdst_q)) begin
        hit    = 1'b1;
        hit_ch = CH_W'(i);
      end
    end
  end

  // In payload the input may only advance when the output register is free
  // or being drained this cycle. Using the register's own valid (rather than
  // the newly selected channel) keeps a still-stalled beat from a previous
  // datagram from being overwritten.
  assign udp_axis_tready_out = (state_q != S_PAYLOAD) || !(|vld_q) ||
                               (|(vld_q & udpdata_tready_in));
  assign acc = udp_axis_tvalid_in && udp_axis_tready_out;

  always_comb begin
    state_d     = state_q;
    hcnt_d      = hcnt_q;
    hsrc_d      = hsrc_q;
    hdst_d      = hdst_q;
    hlen_d      = hlen_q;
    rem_d       = rem_q;
    ch_d        = ch_q;
    src_d       = src_q;
    dst_d       = dst_q;
    ulen_d      = ulen_q;
    data_d      = data_q;
    vld_d       = vld_q & ~udpdata_tready_in;
    last_d      = last_q;
    hdr_vld_d   = 1'b0;
    err_short_d = 1'b0;
    err_len_d   = 1'b0;
    drop_d      = 1'b0;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;

    if (acc) begin
      case (state_q)
        S_HDR: begin
          if (udp_axis_tlast_in && (hcnt_q != 3'd7)) begin
            err_short_d = 1'b1;
            drop_cnt_d  = drop_cnt_q + CNT_W'(1);
            hcnt_d      = 3'd0;
          end else if (hcnt_q == 3'd7) begin
            hcnt_d = 3'd0;
            if (hlen_q < 16'd8) begin
              err_len_d  = 1'b1;
              drop_cnt_d = drop_cnt_q + CNT_W'(1);
            end else if (!hit) begin
              drop_d     = 1'b1;
              drop_cnt_d = drop_cnt_q + CNT_W'(1);
            end else begin
              hdr_vld_d   = 1'b1;
              ch_d        = hit_ch;
              src_d       = hsrc_q;
              dst_d       = hdst_q;
              ulen_d      = hlen_q - 16'd8;
              rem_d       = hlen_q - 16'd8;
              frame_cnt_d = frame_cnt_q + CNT_W'(1);
            end
            // A hit implies len >= 8, so len > 8 means payload remains.
            if (udp_axis_tlast_in)
              state_d = S_HDR;
            else if (hit && (hlen_q > 16'd8) && !(hlen_q < 16'd8))
              state_d = S_PAYLOAD;
            else
              state_d = S_DROP;
          end else begin
            hcnt_d = hcnt_q + 3'd1;
            case (hcnt_q)
              3'd0, 3'd1: hsrc_d = {hsrc_q[7:0], udp_axis_tdata_in};
              3'd2, 3'd3: hdst_d = {hdst_q[7:0], udp_axis_tdata_in};
              3'd4, 3'd5: hlen_d = {hlen_q[7:0], udp_axis_tdata_in};
              default: ;  // checksum bytes are ignored
            endcase
          end
        end

        S_PAYLOAD: begin
          data_d = udp_axis_tdata_in;
          vld_d  = NUM_CH'(1) << ch_q;
          last_d = (rem_q == 16'd1) || udp_axis_tlast_in;
          rem_d  = rem_q - 16'd1;
          if (rem_q == 16'd1) begin
            state_d = udp_axis_tlast_in ? S_HDR : S_DROP;
          end else if (udp_axis_tlast_in) begin
            state_d     = S_HDR;
            err_short_d = 1'b1;
          end
        end

        default: begin
          if (udp_axis_tlast_in)
            state_d = S_HDR;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_HDR;
      hcnt_q      <= '0;
      hsrc_q      <= '0;
      hdst_q      <= '0;
      hlen_q      <= '0;
      rem_q       <= '0;
      ch_q        <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      ulen_q      <= '0;
      data_q      <= '0;
      vld_q       <= '0;
      last_q      <= 1'b0;
      hdr_vld_q   <= 1'b0;
      err_short_q <= 1'b0;
      err_len_q   <= 1'b0;
      drop_q      <= 1'b0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      hcnt_q      <= hcnt_d;
      hsrc_q      <= hsrc_d;
      hdst_q      <= hdst_d;
      hlen_q      <= hlen_d;
      rem_q       <= rem_d;
      ch_q        <= ch_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      ulen_q      <= ulen_d;
      data_q      <= data_d;
      vld_q       <= vld_d;
      last_q      <= last_d;
      hdr_vld_q   <= hdr_vld_d;
      err_short_q <= err_short_d;
      err_len_q   <= err_len_d;
      drop_q      <= drop_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign udpdata_tdata_out  = data_q;
  assign udpdata_tvalid_out = vld_q;
  assign udpdata_tlast_out  = last_q;
  assign hdr_valid_out      = hdr_vld_q;
  assign src_port_out       = src_q;
  assign dest_port_out      = dst_q;
  assign udpdata_length_out = ulen_q;
  assign ch_out             = ch_q;
  assign err_short_out      = err_short_q;
  assign err_len_out        = err_len_q;
  assign drop_out           = drop_q;
  assign frame_cnt_out      = frame_cnt_q;
  assign drop_cnt_out       = drop_cnt_q;

endmodule
